data_memory_access_unit: RTL and testbench

Memory-stage (M) controller between the Execute-to-Memory register and the Memory-to-Writeback register of the pipelined 32-bit MIPS core. It turns MemReadM/MemWriteM into a request/grant/response transaction on a wait-stated data-memory port. While an access is outstanding it holds StallM high. It presents the load result on ReadDataM for capture by the Memory-to-Writeback register.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/data_memory_access_unit.sv | 131 +++++++++++++
 tb/tb_data_memory_access_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and width defaults for the pipelined MIPS core
//               memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mips_pkg;

    // Default data-memory byte address width (driven from ALUOutM)
    localparam int DEFAULT_ADDR_WIDTH = 32;
    // Default load/store data width
    localparam int DEFAULT_DATA_WIDTH = 32;

    // Memory-stage access controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage : mips_pkg

`default_nettype wire

// File: rtl/data_memory_access_unit.sv
// ============================================================================
// Module      : data_memory_access_unit
// Description : Memory-stage controller. Converts MemReadM/MemWriteM into a
//               request/grant/response transaction on a wait-stated data
//               memory port, stalls the pipeline while the access is in
//               flight and holds the last load result on ReadDataM.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module data_memory_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic [ADDR_WIDTH-1:0] ALUOutM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] ReadDataM,
    output logic                  StallM,
    output logic                  AlignErrM,
    output logic                  DMemReq,
    output logic                  DMemWe,
    output logic [ADDR_WIDTH-1:0] DMemAddr,
    output logic [DATA_WIDTH-1:0] DMemWData,
    input  logic                  DMemGnt,
    input  logic                  DMemRValid,
    input  logic [DATA_WIDTH-1:0] DMemRData
);

    mem_state_t            r_state;
    mem_state_t            w_next_state;

    // Request fields captured on acceptance so the port stays stable until grant
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_we;

    logic                  w_access;
    logic                  w_aligned;
    logic                  w_latch;
    logic                  w_capture;

    assign w_access  = MemReadM | MemWriteM;
    assign w_aligned = (ALUOutM[1:0] == 2'b00);

    // Stall is visible in the very first cycle of the access; DONE releases it
    assign StallM    = w_access & (r_state != DONE);

    assign DMemAddr  = r_addr;
    assign DMemWData = r_wdata;
    assign DMemWe    = r_we;

    // Next-state and per-state control decode
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        AlignErrM    = 1'b0;
        DMemReq      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_aligned) begin
                        w_latch      = 1'b1;
                        w_next_state = REQ;
                    end else begin
                        // Misaligned word access is dropped; no request issued
                        AlignErrM    = 1'b1;
                        w_next_state = DONE;
                    end
                end
            end
            REQ: begin
                DMemReq = 1'b1;
                if (DMemGnt) begin
                    w_next_state = r_we ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (DMemRValid) begin
                    w_capture    = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // Pipeline advances at this edge; next instruction starts fresh
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register; reset overrides every transition
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request capture and load-result register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            ReadDataM <= '0;
        end else begin
            if (w_latch) begin
                r_addr  <= ALUOutM;
                r_wdata <= WriteDataM;
                r_we    <= MemWriteM;
            end
            if (w_capture) begin
                ReadDataM <= DMemRData;
            end
        end
    end

endmodule : data_memory_access_unit

`default_nettype wire

// File: tb/tb_data_memory_access_unit.sv
// ============================================================================
// Module      : tb_data_memory_access_unit
// Description : Self-checking bench for data_memory_access_unit. Expected
//               per-cycle behaviour is derived from transaction parameters
//               (grant delay, response delay, alignment) with plain arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_data_memory_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        AlignErrM;
    logic        DMemReq;
    logic        DMemWe;
    logic [31:0] DMemAddr;
    logic [31:0] DMemWData;
    logic        DMemGnt;
    logic        DMemRValid;
    logic [31:0] DMemRData;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rd   = 32'h0;

    always #5 CLK = ~CLK;

    data_memory_access_unit #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .AlignErrM  (AlignErrM),
        .DMemReq    (DMemReq),
        .DMemWe     (DMemWe),
        .DMemAddr   (DMemAddr),
        .DMemWData  (DMemWData),
        .DMemGnt    (DMemGnt),
        .DMemRValid (DMemRValid),
        .DMemRData  (DMemRData)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One cycle with no access; junk read responses must be ignored
    task automatic idle_cycle(input string tag);
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        DMemGnt    = 1'b0;
        DMemRValid = 1'($urandom_range(0, 1));
        DMemRData  = $urandom;
        @(negedge CLK);
        n_checks++;
        if (StallM !== 1'b0 || DMemReq !== 1'b0 || AlignErrM !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle ctrl: stall=%b req=%b alignerr=%b, want 0 0 0",
                     tag, StallM, DMemReq, AlignErrM);
        end
        n_checks++;
        if (ReadDataM !== exp_rd) begin
            n_fail++;
            $display("FAIL %s idle ReadDataM: got %h want %h", tag, ReadDataM, exp_rd);
        end
        step();
    endtask

    // One complete access: g cycles without grant, r WAIT cycles without rvalid
    task automatic do_access(input bit is_load, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int g, input int r, input string tag);
        bit aligned;
        int n;
        bit in_wait;
        bit exp_req;
        aligned = (addr[1:0] == 2'b00);
        n = !aligned ? 1 : (is_load ? g + r + 3 : g + 2);
        for (int k = 0; k <= n; k++) begin
            MemReadM   = is_load;
            MemWriteM  = !is_load;
            ALUOutM    = addr;
            WriteDataM = wdata;
            DMemGnt    = aligned && (k == g + 1);
            DMemRValid = 1'b0;
            DMemRData  = $urandom;
            in_wait    = aligned && is_load && (k >= g + 2) && (k <= g + r + 2);
            if (aligned && is_load && k == g + r + 2) begin
                DMemRValid = 1'b1;
                DMemRData  = rdata;
            end else if (!in_wait && !(aligned && k == g + 1)) begin
                DMemRValid = 1'($urandom_range(0, 1));
            end
            exp_req = aligned && (k >= 1) && (k <= g + 1);
            @(negedge CLK);
            if (k == n && aligned && is_load) exp_rd = rdata;

            n_checks++;
            if (StallM !== (k < n)) begin
                n_fail++;
                $display("FAIL %s k=%0d StallM: got %b want %b", tag, k, StallM, (k < n));
            end
            n_checks++;
            if (DMemReq !== exp_req) begin
                n_fail++;
                $display("FAIL %s k=%0d DMemReq: got %b want %b", tag, k, DMemReq, exp_req);
            end
            n_checks++;
            if (AlignErrM !== (!aligned && k == 0)) begin
                n_fail++;
                $display("FAIL %s k=%0d AlignErrM: got %b want %b", tag, k, AlignErrM,
                         (!aligned && k == 0));
            end
            if (exp_req) begin
                n_checks++;
                if (DMemAddr !== addr || DMemWe !== !is_load) begin
                    n_fail++;
                    $display("FAIL %s k=%0d req fields: addr %h we %b want %h %b",
                             tag, k, DMemAddr, DMemWe, addr, !is_load);
                end
                if (!is_load) begin
                    n_checks++;
                    if (DMemWData !== wdata) begin
                        n_fail++;
                        $display("FAIL %s k=%0d DMemWData: got %h want %h", tag, k, DMemWData, wdata);
                    end
                end
            end
            n_checks++;
            if (ReadDataM !== exp_rd) begin
                n_fail++;
                $display("FAIL %s k=%0d ReadDataM: got %h want %h", tag, k, ReadDataM, exp_rd);
            end
            step();
        end
        DMemGnt    = 1'b0;
        DMemRValid = 1'b0;
    endtask

    task automatic test_reset();
        RST        = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        DMemGnt    = 1'b0;
        DMemRValid = 1'b0;
        DMemRData  = 32'h0;
        step();
        step();
        @(negedge CLK);
        n_checks++;
        if (StallM !== 1'b0 || DMemReq !== 1'b0 || AlignErrM !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ctrl: stall=%b req=%b alignerr=%b, want 0 0 0",
                     StallM, DMemReq, AlignErrM);
        end
        n_checks++;
        if (ReadDataM !== 32'h0 || DMemAddr !== 32'h0 || DMemWData !== 32'h0) begin
            n_fail++;
            $display("FAIL reset regs: rd=%h addr=%h wdata=%h, want zeros",
                     ReadDataM, DMemAddr, DMemWData);
        end
        // Stall follows an access even while held in reset
        MemReadM = 1'b1;
        #1;
        n_checks++;
        if (StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL reset access StallM: got %b want 1", StallM);
        end
        step();
        MemReadM = 1'b0;
        RST      = 1'b0;
        exp_rd   = 32'h0;
        step();
    endtask

    task automatic test_load_basic();
        do_access(1'b1, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, "load_basic");
        idle_cycle("load_basic_after");
    endtask

    task automatic test_store_wait();
        do_access(1'b0, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 3, 0, "store_wait");
        idle_cycle("store_wait_after");
    endtask

    task automatic test_misaligned();
        do_access(1'b1, 32'h0000_0013, 32'h0, 32'h5555_AAAA, 0, 0, "misaligned");
        idle_cycle("misaligned_after");
    endtask

    task automatic test_reset_in_flight();
        do_access(1'b1, 32'h0000_0040, 32'h0, 32'h1234_5678, 0, 0, "pre_reset_load");
        idle_cycle("pre_reset_idle");
        // Reset while in WAIT, then a late response arrives
        MemReadM = 1'b1; ALUOutM = 32'h0000_0044; DMemGnt = 1'b0; DMemRValid = 1'b0;
        step();
        DMemGnt = 1'b1;
        step();
        DMemGnt = 1'b0;
        RST     = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (DMemReq !== 1'b0 || StallM !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_wait before: req=%b stall=%b want 0 1", DMemReq, StallM);
        end
        step();
        exp_rd     = 32'h0;
        RST        = 1'b0;
        MemReadM   = 1'b0;
        DMemRValid = 1'b1;
        DMemRData  = 32'hBAD0_BAD0;
        @(negedge CLK);
        n_checks++;
        if (StallM !== 1'b0 || DMemReq !== 1'b0 || ReadDataM !== exp_rd) begin
            n_fail++;
            $display("FAIL rst_wait after: stall=%b req=%b rd=%h want 0 0 %h",
                     StallM, DMemReq, ReadDataM, exp_rd);
        end
        step();
        DMemRValid = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (ReadDataM !== exp_rd || DMemReq !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wait late rvalid: rd=%h req=%b want %h 0", ReadDataM, DMemReq, exp_rd);
        end
        step();
        // Reset while in REQ with no grant: request must drop next cycle
        MemWriteM = 1'b1; ALUOutM = 32'h0000_0080; WriteDataM = 32'h0BAD_F00D;
        step();
        RST = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (DMemReq !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_req before: req=%b want 1", DMemReq);
        end
        step();
        RST       = 1'b0;
        MemWriteM = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (DMemReq !== 1'b0 || StallM !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req after: req=%b stall=%b want 0 0", DMemReq, StallM);
        end
        step();
        idle_cycle("rst_req_idle");
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 32'h0000_0100, 32'h0, 32'hA5A5_0001, 1, 1, "b2b_load");
        do_access(1'b0, 32'h0000_0104, 32'h7777_8888, 32'h0, 0, 0, "b2b_store");
        do_access(1'b1, 32'h0000_0108, 32'h0, 32'h0F0F_F0F0, 0, 2, "b2b_load2");
        idle_cycle("b2b_after");
    endtask

    task automatic test_random();
        bit          is_load;
        bit          mis;
        logic [31:0] addr;
        for (int t = 0; t < 60; t++) begin
            is_load = 1'($urandom_range(0, 1));
            mis     = ($urandom_range(0, 3) == 0);
            addr    = $urandom & 32'hFFFF_FFFC;
            if (mis) addr[1:0] = 2'($urandom_range(1, 3));
            do_access(is_load, addr, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3), "random");
            if ($urandom_range(0, 1) == 1) idle_cycle("random_gap");
        end
        idle_cycle("random_end");
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_wait();
        test_misaligned();
        test_reset_in_flight();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_memory_access_unit

`default_nettype wire
